uart_out_fifo: RTL and testbench

//   Buffered console-output stage downstream of the core's putch path; drives the
//   top-level io_uart_out_valid/io_uart_out_ch pair. Putch characters from the core
//   are queued in a FIFO and emitted in order, one per handshake, with optional pacing.

---
 rtl/uart_out_fifo_if.sv | 28 ++
 rtl/uart_out_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_out_fifo.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_out_fifo_if.sv
// Handshake bundle between the core's putch path, the output FIFO and the UART sink.
// The FIFO uses the slave modport; the core/sink environment uses the master modport.
interface uart_out_fifo_if;
    logic       putch_valid;
    logic [7:0] putch_ch;
    logic       putch_ready;
    logic       uart_out_valid;
    logic [7:0] uart_out_ch;
    logic       uart_out_ready;

    modport slave (
        input  putch_valid,
        input  putch_ch,
        input  uart_out_ready,
        output putch_ready,
        output uart_out_valid,
        output uart_out_ch
    );

    modport master (
        output putch_valid,
        output putch_ch,
        output uart_out_ready,
        input  putch_ready,
        input  uart_out_valid,
        input  uart_out_ch
    );
endinterface

// File: rtl/uart_out_fifo.sv
// Buffered console-output stage: queues putch characters and emits them in order with
// optional pacing. Overflow never stalls the core; lost characters are counted instead.
module uart_out_fifo #(
    parameter int DEPTH = 16,
    parameter int GAP   = 0,
    parameter int CNT_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    uart_out_fifo_if.slave             bus,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];

    logic full, empty, push, drop, send, pop;

    // Readiness comes only from registered level, so a pop never frees a slot the same cycle.
    always_comb begin
        full  = (level_q == FULL_LVL);
        empty = (level_q == '0);
        bus.putch_ready = !full && !reset;
        push  = bus.putch_valid && bus.putch_ready;
        drop  = bus.putch_valid && !bus.putch_ready;
        send  = (state_q == SEND);
        pop   = send && bus.uart_out_ready;

        bus.uart_out_valid = send;
        bus.uart_out_ch    = send ? mem_q[rd_ptr_q] : 8'h00;
        fifo_level         = level_q;
        drop_cnt           = drop_cnt_q;
        busy               = (state_q != IDLE) || !empty;
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus.putch_ch;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Staying in SEND when anything is left after the pop keeps GAP=0 at one char per cycle.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (pop) begin
                    if (GAP > 0) begin
                        state_d = GAP_WAIT;
                        gap_d   = GAP_LOAD;
                    end else if (level_d != '0) begin
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP_WAIT: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            gap_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            gap_q      <= gap_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: entries are only ever read after being written.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_out_fifo.sv
// Directed bench for uart_out_fifo: a GAP=0 instance checked through a scoreboard monitor
// and a GAP=3 instance checked cycle by cycle for pacing.
module tb_uart_out_fifo;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    uart_out_fifo_if bus0 ();
    uart_out_fifo_if bus1 ();

    logic [4:0]  lvl0, lvl1;
    logic [31:0] drop0, drop1;
    logic        busy0, busy1;

    uart_out_fifo #(.DEPTH(16), .GAP(0), .CNT_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus0),
        .fifo_level (lvl0),
        .drop_cnt   (drop0),
        .busy       (busy0)
    );

    uart_out_fifo #(.DEPTH(16), .GAP(3), .CNT_W(32)) dut_gap (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus1),
        .fifo_level (lvl1),
        .drop_cnt   (drop1),
        .busy       (busy1)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] sb [$];
    logic       prev_stall  = 1'b0;
    logic [7:0] prev_ch     = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] ch, input logic rdy, input logic accept);
        bus0.putch_valid    = v;
        bus0.putch_ch       = ch;
        bus0.uart_out_ready = rdy;
        if (v && accept) sb.push_back(ch);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        bus1.putch_valid    = 1'b0;
        bus1.putch_ch       = 8'h00;
        bus1.uart_out_ready = 1'b1;
        @(negedge clock);
        checkOutput("ready_in_reset", 32'(bus0.putch_ready), 32'd0);
        tick();
        @(negedge clock);
        checkOutput("rst_valid", 32'(bus0.uart_out_valid), 32'd0);
        checkOutput("rst_ch",    32'(bus0.uart_out_ch),    32'd0);
        checkOutput("rst_level", 32'(lvl0),                32'd0);
        checkOutput("rst_drop",  drop0,                    32'd0);
        checkOutput("rst_busy",  32'(busy0),               32'd0);
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    // Scoreboard monitor: every handshake pops one expected char; a stall must hold data.
    always @(negedge clock) begin
        if (!reset) begin
            if (prev_stall) begin
                checkOutput("hold_valid", 32'(bus0.uart_out_valid), 32'd1);
                checkOutput("hold_ch",    32'(bus0.uart_out_ch),    32'(prev_ch));
            end
            if (bus0.uart_out_valid && bus0.uart_out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", 32'(bus0.uart_out_valid), 32'd0);
                end else begin
                    logic [7:0] exp_ch;
                    exp_ch = sb.pop_front();
                    checkOutput("order", 32'(bus0.uart_out_ch), 32'(exp_ch));
                end
            end
            prev_stall = bus0.uart_out_valid && !bus0.uart_out_ready;
            prev_ch    = bus0.uart_out_ch;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        bus1.putch_valid    = 1'b0;
        bus1.putch_ch       = 8'h00;
        bus1.uart_out_ready = 1'b1;
        tick();

        $display("[TB] single character latency");
        do_reset();
        applyStimulus(1'b1, 8'h41, 1'b1, 1'b1);
        @(negedge clock);
        checkOutput("t1_c0_valid", 32'(bus0.uart_out_valid), 32'd0);
        checkOutput("t1_c0_ready", 32'(bus0.putch_ready),    32'd1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("t1_c1_valid", 32'(bus0.uart_out_valid), 32'd0);
        checkOutput("t1_c1_level", 32'(lvl0),                32'd1);
        checkOutput("t1_c1_busy",  32'(busy0),               32'd1);
        tick();
        @(negedge clock);
        checkOutput("t1_c2_valid", 32'(bus0.uart_out_valid), 32'd1);
        checkOutput("t1_c2_ch",    32'(bus0.uart_out_ch),    32'h41);
        checkOutput("t1_c2_level", 32'(lvl0),                32'd1);
        tick();
        @(negedge clock);
        checkOutput("t1_c3_valid", 32'(bus0.uart_out_valid), 32'd0);
        checkOutput("t1_c3_ch",    32'(bus0.uart_out_ch),    32'd0);
        checkOutput("t1_c3_level", 32'(lvl0),                32'd0);
        checkOutput("t1_c3_busy",  32'(busy0),               32'd0);
        tick();

        $display("[TB] back-to-back burst");
        do_reset();
        for (int c = 0; c < 19; c++) begin
            if (c < 16) applyStimulus(1'b1, 8'(c), 1'b1, 1'b1);
            else        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clock);
            checkOutput("t2_valid", 32'(bus0.uart_out_valid), 32'(c >= 2 && c <= 17));
            if (c >= 2 && c <= 17) checkOutput("t2_ch", 32'(bus0.uart_out_ch), 32'(c - 2));
            tick();
        end
        checkOutput("t2_drop",    drop0,            32'd0);
        checkOutput("t2_sb_left", 32'(sb.size()),   32'd0);

        $display("[TB] overflow");
        do_reset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, i < 16);
            @(negedge clock);
            if (i == 16) checkOutput("t3_ready_full", 32'(bus0.putch_ready), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("t3_level_full", 32'(lvl0),                32'd16);
        checkOutput("t3_ready",      32'(bus0.putch_ready),    32'd0);
        checkOutput("t3_drop",       drop0,                    32'd4);
        checkOutput("t3_first_ch",   32'(bus0.uart_out_ch),    32'h80);
        tick();
        @(negedge clock);
        checkOutput("t3_ready_pop",  32'(bus0.putch_ready),    32'd1);
        checkOutput("t3_level_pop",  32'(lvl0),                32'd15);
        tick();
        for (int i = 0; i < 20; i++) tick();
        checkOutput("t3_sb_left",    32'(sb.size()),           32'd0);
        checkOutput("t3_level_end",  32'(lvl0),                32'd0);

        $display("[TB] reset mid-burst");
        checkOutput("t6_drop_before", drop0, 32'd4);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1);
            tick();
        end
        for (int c = 8; c < 11; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            if (c == 10) reset = 1'b1;
            @(negedge clock);
            if (c == 10) begin
                checkOutput("t6_third_valid", 32'(bus0.uart_out_valid), 32'd1);
                checkOutput("t6_third_ch",    32'(bus0.uart_out_ch),    32'hA2);
                checkOutput("t6_ready_rst",   32'(bus0.putch_ready),    32'd0);
            end
            tick();
        end
        sb.delete();
        @(negedge clock);
        checkOutput("t6_valid_after", 32'(bus0.uart_out_valid), 32'd0);
        checkOutput("t6_level_after", 32'(lvl0),                32'd0);
        checkOutput("t6_drop_after",  drop0,                    32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checkOutput("t6_quiet", 32'(bus0.uart_out_valid), 32'd0);
            tick();
        end

        $display("[TB] backpressure");
        do_reset();
        for (int c = 0; c < 14; c++) begin
            applyStimulus(c < 3, 8'(8'h61 + c), c[0], c < 3);
            @(negedge clock);
            tick();
        end
        checkOutput("t4_sb_left",   32'(sb.size()), 32'd0);
        checkOutput("t4_level_end", 32'(lvl0),      32'd0);

        $display("[TB] pacing with GAP=3");
        do_reset();
        for (int c = 0; c < 10; c++) begin
            bus1.putch_valid    = (c < 2);
            bus1.putch_ch       = (c == 0) ? 8'h31 : 8'h32;
            bus1.uart_out_ready = 1'b1;
            @(negedge clock);
            checkOutput("t5_valid", 32'(bus1.uart_out_valid), 32'(c == 2 || c == 7));
            checkOutput("t5_ch", 32'(bus1.uart_out_ch),
                        (c == 2) ? 32'h31 : (c == 7) ? 32'h32 : 32'h00);
            if (c == 4) checkOutput("t5_busy_gap", 32'(busy1), 32'd1);
            tick();
        end
        checkOutput("t5_level_end", 32'(lvl1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
